// File: rtl/mil_txd_if.sv
// rtl/mil_txd_if.sv - start/data handshake and line-drive bundle for mil_txd
// Purpose: groups the request, status and line signals of the 1553 word transmitter.
// Signals:
//   st_i      start request, honoured when ready_o=1
//   dat_i     16-bit word, captured at the accepting edge
//   cw_dw_i   1=command/status sync, 0=data sync, captured with dat_i
//   ready_o   a start is legal this cycle
//   busy_o    frame in progress
//   done_o    one-clk pulse during the final clock of a frame
//   cb_bit_o  current bit-time index 0..19
//   out_p_o   positive line drive (registered)
//   out_n_o   negative line drive (registered)
interface mil_txd_if;
  logic        st_i;
  logic [15:0] dat_i;
  logic        cw_dw_i;
  logic        ready_o;
  logic        busy_o;
  logic        done_o;
  logic [4:0]  cb_bit_o;
  logic        out_p_o;
  logic        out_n_o;

  modport master (
    output st_i, dat_i, cw_dw_i,
    input  ready_o, busy_o, done_o, cb_bit_o, out_p_o, out_n_o
  );

  modport slave (
    input  st_i, dat_i, cw_dw_i,
    output ready_o, busy_o, done_o, cb_bit_o, out_p_o, out_n_o
  );
endinterface

// File: rtl/mil_txd.sv
// rtl/mil_txd.sv - MIL-STD-1553 Manchester-II word transmitter
// Purpose: sends one 20-bit-time word (3-bit sync, 16 data bits MSB first, odd
// parity) as complementary line drives; words can be chained with no gap.
// Ports:
//   clk   system clock, all logic on posedge
//   rst   asynchronous active-high reset
//   bus   mil_txd_if.slave: st/dat/cw_dw in; ready/busy/done/cb_bit/out_p/out_n out
module mil_txd #(
  parameter int FCLK   = 50_000_000,
  parameter int TX_VEL = 1_000_000
) (
  input  logic     clk,
  input  logic     rst,
  mil_txd_if.slave bus
);

  localparam int HB  = FCLK / (2 * TX_VEL);
  localparam int HBW = (HB > 1) ? $clog2(HB) : 1;
  localparam logic [HBW-1:0] HB_LAST = HBW'(HB - 1);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_PAR} state_t;

  state_t         state_q, state_d;
  logic [HBW-1:0] hb_q, hb_d;      // clock within the current half-bit
  logic [5:0]     half_q, half_d;  // half-bit index within the frame, 0..39
  logic [15:0]    sr_q, sr_d;
  logic           par_q, par_d;
  logic           cw_q, cw_d;
  logic           out_p_q, out_p_d;
  logic           out_n_q, out_n_d;

  logic       hb_end, frame_end, busy, start;
  logic [5:0] half_nxt;

  // Line level for a given half-bit: sync halves 0..5, then Manchester bits
  // where the even half carries the bit value and the odd half its complement.
  function automatic logic line_level(input logic [5:0] half, input logic bit_v,
                                      input logic cw);
    if (half < 6'd6) return cw ? (half < 6'd3) : (half >= 6'd3);
    else             return half[0] ? ~bit_v : bit_v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hb_q    <= '0;
      half_q  <= '0;
      sr_q    <= '0;
      par_q   <= 1'b0;
      cw_q    <= 1'b0;
      out_p_q <= 1'b0;
      out_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hb_q    <= hb_d;
      half_q  <= half_d;
      sr_q    <= sr_d;
      par_q   <= par_d;
      cw_q    <= cw_d;
      out_p_q <= out_p_d;
      out_n_q <= out_n_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hb_d     = hb_q;
    half_d   = half_q;
    sr_d     = sr_q;
    par_d    = par_q;
    cw_d     = cw_q;
    out_p_d  = 1'b0;
    out_n_d  = 1'b0;
    half_nxt = half_q + 6'd1;

    hb_end    = (hb_q == HB_LAST);
    frame_end = (state_q == S_PAR) && (half_q == 6'd39) && hb_end;
    busy      = (state_q != S_IDLE);
    start     = bus.st_i && (!busy || frame_end);

    if (start) begin
      // Also taken at frame_end, so the next sync follows with no idle clock.
      state_d = S_SYNC;
      hb_d    = '0;
      half_d  = '0;
      sr_d    = bus.dat_i;
      par_d   = ~^bus.dat_i;
      cw_d    = bus.cw_dw_i;
    end else if (frame_end) begin
      state_d = S_IDLE;
      hb_d    = '0;
      half_d  = '0;
    end else if (busy) begin
      if (hb_end) begin
        hb_d   = '0;
        half_d = half_nxt;
        // A data bit ends after its odd half; present the next bit at sr[15].
        if (state_q == S_DATA && half_q[0]) sr_d = {sr_q[14:0], 1'b0};
        if (half_nxt < 6'd6)       state_d = S_SYNC;
        else if (half_nxt < 6'd38) state_d = S_DATA;
        else                       state_d = S_PAR;
      end else begin
        hb_d = hb_q + HBW'(1);
      end
    end

    // Lines are registered from next-state so the first sync level appears
    // right after the accepting edge.
    if (state_d != S_IDLE) begin
      out_p_d = line_level(half_d, (state_d == S_PAR) ? par_d : sr_d[15], cw_d);
      out_n_d = ~out_p_d;
    end
  end

  assign bus.busy_o   = busy;
  assign bus.done_o   = frame_end;
  assign bus.ready_o  = !busy || frame_end;
  assign bus.cb_bit_o = half_q[5:1];
  assign bus.out_p_o  = out_p_q;
  assign bus.out_n_o  = out_n_q;

endmodule

// File: tb/tb_mil_txd.sv
// tb/tb_mil_txd.sv - directed self-checking bench for mil_txd
module tb_mil_txd;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mil_txd_if bus ();

  mil_txd dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic       rec_p [0:2000];
  logic       rec_n [0:2000];
  logic       rec_busy [0:2000];
  logic       rec_done [0:2000];
  logic       rec_rdy [0:2000];
  logic [4:0] rec_cb [0:2000];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected Out_P for clock kk (0..999) of a frame carrying d with sync cw.
  function automatic logic exp_level(input int kk, input logic [15:0] d, input logic cw);
    int   h;
    logic b;
    h = kk / 25;
    if (h < 6) return cw ? (h < 3) : (h >= 3);
    if (h < 38) b = d[15 - (h - 6) / 2];
    else        b = ~^d;
    return (h % 2 == 0) ? b : ~b;
  endfunction

  task automatic start_word(input logic [15:0] d, input logic cw, input bit keep_st);
    @(negedge clk);
    bus.dat_i   = d;
    bus.cw_dw_i = cw;
    bus.st_i    = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_st) bus.st_i = 1'b0;
  endtask

  // Record n clocks starting with the current one; mode injects mid-frame stimulus.
  task automatic capture(input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      rec_p[k]    = bus.out_p_o;
      rec_n[k]    = bus.out_n_o;
      rec_busy[k] = bus.busy_o;
      rec_done[k] = bus.done_o;
      rec_rdy[k]  = bus.ready_o;
      rec_cb[k]   = bus.cb_bit_o;
      if (mode == 1 && k == 500)  bus.dat_i = 16'h5A5A;
      if (mode == 1 && k == 1999) bus.st_i = 1'b0;
      if (mode == 2 && k == 10)   bus.dat_i = 16'h1234;
      if (mode == 2 && k == 500)  bus.st_i = 1'b1;
      if (mode == 2 && k == 501)  bus.st_i = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  // Compare recorded clocks 0..nf*1000 against nf back-to-back frames then idle.
  task automatic check_frames(input string tag, input int nf,
                              input logic [15:0] d0, input logic cw0,
                              input logic [15:0] d1, input logic cw1);
    int e_p, e_n, e_b, e_d, e_c, e_r;
    logic ep;
    e_p = 0; e_n = 0; e_b = 0; e_d = 0; e_c = 0; e_r = 0;
    for (int k = 0; k <= nf * 1000; k++) begin
      int kk;
      bit act;
      kk  = k % 1000;
      act = (k < nf * 1000);
      ep  = act ? ((k < 1000) ? exp_level(kk, d0, cw0) : exp_level(kk, d1, cw1)) : 1'b0;
      if (rec_p[k] !== ep) e_p++;
      if (rec_n[k] !== (act ? ~ep : 1'b0)) e_n++;
      if (rec_busy[k] !== act) e_b++;
      if (rec_done[k] !== (act && kk == 999)) e_d++;
      if (rec_rdy[k] !== (!act || kk == 999)) e_r++;
      if (rec_cb[k] !== (act ? 5'(kk / 50) : 5'd0)) e_c++;
    end
    check({tag, "_out_p_errs"}, e_p, 0);
    check({tag, "_out_n_errs"}, e_n, 0);
    check({tag, "_busy_errs"}, e_b, 0);
    check({tag, "_done_errs"}, e_d, 0);
    check({tag, "_ready_errs"}, e_r, 0);
    check({tag, "_cb_bit_errs"}, e_c, 0);
  endtask

  initial begin
    logic [15:0] word;
    logic        sync_ok, manch_ok;

    bus.st_i    = 1'b0;
    bus.dat_i   = 16'h0000;
    bus.cw_dw_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_p", bus.out_p_o, 0);
    check("rst_out_n", bus.out_n_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_cb_bit", bus.cb_bit_o, 0);
    check("rst_ready", bus.ready_o, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 1: command sync, all-zero data
    start_word(16'h0000, 1'b1, 1'b0);
    capture(1001, 0);
    check("t1_p0", rec_p[0], 1);
    check("t1_p74", rec_p[74], 1);
    check("t1_p75", rec_p[75], 0);
    check("t1_p150", rec_p[150], 0);
    check("t1_p175", rec_p[175], 1);
    check("t1_p950", rec_p[950], 1);
    check("t1_p975", rec_p[975], 0);
    check("t1_done998", rec_done[998], 0);
    check("t1_done999", rec_done[999], 1);
    check("t1_cb999", rec_cb[999], 19);
    check("t1_p1000", rec_p[1000], 0);
    check("t1_busy1000", rec_busy[1000], 0);
    check_frames("t1", 1, 16'h0000, 1'b1, 16'h0000, 1'b1);

    // 2: data sync, all-ones data
    start_word(16'hFFFF, 1'b0, 1'b0);
    capture(1001, 0);
    check("t2_p0", rec_p[0], 0);
    check("t2_p75", rec_p[75], 1);
    check("t2_p150", rec_p[150], 1);
    check("t2_p175", rec_p[175], 0);
    check_frames("t2", 1, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0);

    // 3: 0x0001 with parity 0, decoded independently from the line
    start_word(16'h0001, 1'b1, 1'b0);
    capture(1001, 0);
    sync_ok  = (rec_p[37] == 1'b1) && (rec_p[112] == 1'b0) &&
               (rec_n[37] == 1'b0) && (rec_n[112] == 1'b1);
    manch_ok = 1'b1;
    word     = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      word = {word[14:0], rec_p[25 * (6 + 2 * i) + 12]};
      if (rec_p[25 * (7 + 2 * i) + 12] == rec_p[25 * (6 + 2 * i) + 12]) manch_ok = 1'b0;
    end
    check("t3_decoded", word, 16'h0001);
    check("t3_sync_ok", sync_ok, 1);
    check("t3_manchester_ok", manch_ok, 1);
    check("t3_parity_first", rec_p[962], 0);
    check("t3_parity_second", rec_p[987], 1);
    check_frames("t3", 1, 16'h0001, 1'b1, 16'h0001, 1'b1);

    // 4: st held high, two contiguous words
    start_word(16'hA5A5, 1'b1, 1'b1);
    capture(2001, 1);
    check("t4_busy999", rec_busy[999], 1);
    check("t4_busy1000", rec_busy[1000], 1);
    check("t4_p1000", rec_p[1000], 1);
    check_frames("t4", 2, 16'hA5A5, 1'b1, 16'h5A5A, 1'b1);

    // 5: async reset mid-frame, then a clean frame
    start_word(16'hFFFF, 1'b1, 1'b0);
    capture(400, 0);
    check("t5_pre_rst_p", bus.out_p_o, 1);
    check("t5_pre_rst_busy", bus.busy_o, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_out_p", bus.out_p_o, 0);
    check("t5_rst_out_n", bus.out_n_o, 0);
    check("t5_rst_busy", bus.busy_o, 0);
    check("t5_rst_cb_bit", bus.cb_bit_o, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    start_word(16'h1234, 1'b0, 1'b0);
    capture(1001, 0);
    check_frames("t5", 1, 16'h1234, 1'b0, 16'h1234, 1'b0);

    // 6: dat changed and st pulsed while busy; line still carries BEEF
    start_word(16'hBEEF, 1'b1, 1'b0);
    capture(1001, 2);
    check_frames("t6", 1, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
